// File: rtl/multiplier.sv
// Memory-mapped shift-free multiplier: product = A added to itself B times, one add per clock.
// Build option MULT_FAST_SWAP_EN: iterate over min(A,B) instead of B (same result, shorter run).
module multiplier #(
  parameter int DATA_W = 32,
  parameter int LED_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wstrb,
  input  logic              rstrb,
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              wbusy,
  output logic              rbusy,
  output logic [LED_W-1:0]  LED,
  output logic              state_dbg
);

  // Bus handshake: a write happens on every rising clk edge with wstrb=1 (no
  // acknowledge); reads are a pure combinational mux on sel and never stall.
  // wbusy=1 means A/B/CTRL writes are dropped until the run completes.

  localparam logic [1:0] SEL_A      = 2'b00;
  localparam logic [1:0] SEL_B      = 2'b01;
  localparam logic [1:0] SEL_CTRL   = 2'b10;
  localparam logic [1:0] SEL_RESULT = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] addend;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] result;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] start_addend;
  logic [DATA_W-1:0] start_count;
  logic              unused_rstrb;

  assign unused_rstrb = rstrb;

`ifdef MULT_FAST_SWAP_EN
  // Loop over the smaller operand; addition is commutative so the product is unchanged.
  always_comb begin
    start_addend = a;
    start_count  = b;
    if (a < b) begin
      start_addend = b;
      start_count  = a;
    end
  end
`else
  always_comb begin
    start_addend = a;
    start_count  = b;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      addend <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wstrb) begin
            case (sel)
              SEL_A: a <= wdata;
              SEL_B: b <= wdata;
              SEL_CTRL: begin
                if (wdata[0]) begin
                  addend <= start_addend;
                  cnt    <= start_count;
                  acc    <= '0;
                  busy   <= 1'b1;
                  done   <= 1'b0;
                  state  <= RUN;
                end
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          // The cnt==0 cycle is the extra one that publishes the product.
          if (cnt != '0) begin
            acc <= acc + addend;
            cnt <= cnt - 1'b1;
          end else begin
            result <= acc;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_A:      rdata = a;
      SEL_B:      rdata = b;
      SEL_CTRL:   rdata = {{(DATA_W-2){1'b0}}, done, busy};
      SEL_RESULT: rdata = result;
      default:    rdata = '0;
    endcase
  end

  assign wbusy     = busy;
  assign rbusy     = 1'b0;
  assign LED       = result[LED_W-1:0];
  assign state_dbg = (state == RUN);

endmodule

// File: tb/tb_multiplier.sv
// Directed bench for multiplier: driver tasks issue register writes, a monitor
// checks each completed run (LED value and busy length) against a scoreboard queue.
module tb_multiplier;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         wstrb;
  logic         rstrb;
  logic [1:0]   sel;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata;
  logic         wbusy;
  logic         rbusy;
  logic [7:0]   led;
  logic         state_dbg;

  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  int           total;
  int           bad;
  int           run_len;
  logic [W-1:0] v;

  multiplier #(.DATA_W(W), .LED_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .wstrb     (wstrb),
    .rstrb     (rstrb),
    .sel       (sel),
    .wdata     (wdata),
    .rdata     (rdata),
    .wbusy     (wbusy),
    .rbusy     (rbusy),
    .LED       (led),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1; consecutive calls write on consecutive edges.
  task automatic wr(input logic [1:0] s, input logic [W-1:0] d);
    sel   = s;
    wdata = d;
    wstrb = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wstrb = 1'b0;
    wdata = '0;
  endtask

  task automatic rd(input logic [1:0] s, output logic [W-1:0] val);
    wstrb = 1'b0;
    sel   = s;
    @(negedge clk);
    val = rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (wbusy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (wbusy) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got busy after %0d cycles want idle", name, n);
    end
    @(posedge clk);
    #1;
  endtask

  // Push expectation, then load A, B and start on three consecutive edges.
  task automatic run_mult(input logic [W-1:0] opa, input logic [W-1:0] opb,
                          input logic [W-1:0] prod, input int cyc_slow, input int cyc_fast);
    exp_q.push_back(prod);
`ifdef MULT_FAST_SWAP_EN
    cyc_q.push_back(cyc_fast);
`else
    cyc_q.push_back(cyc_slow);
`endif
    wr(2'b00, opa);
    wr(2'b01, opb);
    wr(2'b10, 32'h1);
    idle();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      run_len = 0;
    end else if (wbusy) begin
      run_len++;
    end else if (run_len != 0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_completion: got run of %0d cycles want none", run_len);
      end else begin
        logic [W-1:0] e;
        int c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("mon_led", {24'h0, led}, {24'h0, e[7:0]});
        check("mon_busy_cycles", run_len, c);
      end
      run_len = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    total   = 0;
    bad     = 0;
    run_len = 0;
    rst     = 1'b0;
    wstrb   = 1'b0;
    rstrb   = 1'b0;
    sel     = 2'b00;
    wdata   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_wbusy", {31'h0, wbusy}, 32'h0);
    check("rst_rbusy", {31'h0, rbusy}, 32'h0);
    check("rst_led", {24'h0, led}, 32'h0);
    rd(2'b00, v); check("rst_a", v, 32'h0);
    rd(2'b01, v); check("rst_b", v, 32'h0);
    rd(2'b10, v); check("rst_status", v, 32'h0);
    rd(2'b11, v); check("rst_result", v, 32'h0);

    // Basic 7*5
    run_mult(32'd7, 32'd5, 32'd35, 6, 6);
    rstrb = 1'b1;
    rd(2'b10, v); check("basic_status_busy", v, 32'h1);
    rstrb = 1'b0;
    wait_done("basic");
    rd(2'b11, v); check("basic_result", v, 32'd35);
    check("basic_led", {24'h0, led}, 32'h23);
    rd(2'b10, v); check("basic_status_done", v, 32'h2);

    // Zero operand
    run_mult(32'd123, 32'd0, 32'd0, 1, 1);
    wait_done("zero");
    rd(2'b11, v); check("zero_result", v, 32'd0);
    check("zero_led", {24'h0, led}, 32'h0);

    // Overflow truncation
    run_mult(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 3, 3);
    wait_done("ovf");
    rd(2'b11, v); check("ovf_result", v, 32'hFFFF_FFFE);
    check("ovf_led", {24'h0, led}, 32'hFE);

    // Writes while busy are dropped; a second start must not occur
    run_mult(32'd7, 32'd5, 32'd35, 6, 6);
    wr(2'b00, 32'd9);
    wr(2'b10, 32'h1);
    wr(2'b01, 32'd1);
    idle();
    wait_done("busywr");
    repeat (3) @(posedge clk);
    #1;
    check("busywr_idle", {31'h0, wbusy}, 32'h0);
    rd(2'b11, v); check("busywr_result", v, 32'd35);
    rd(2'b00, v); check("busywr_a", v, 32'd7);
    rd(2'b01, v); check("busywr_b", v, 32'd5);

    // Result register is read-only; CTRL with bit0=0 does not start
    wr(2'b11, 32'hDEAD_BEEF);
    wr(2'b10, 32'h2);
    idle();
    @(negedge clk);
    check("ctrl0_nostart", {31'h0, wbusy}, 32'h0);
    rd(2'b11, v); check("ro_result", v, 32'd35);

    // Operand order: 3*100
    run_mult(32'd3, 32'd100, 32'd300, 101, 4);
    wait_done("swap");
    rd(2'b11, v); check("swap_result", v, 32'd300);
    check("swap_led", {24'h0, led}, 32'h2C);
    rd(2'b00, v); check("swap_a", v, 32'd3);
    rd(2'b01, v); check("swap_b", v, 32'd100);

    // Async reset mid-run: no expectation pushed, run must vanish
    wr(2'b00, 32'd4);
    wr(2'b01, 32'd10);
    wr(2'b10, 32'h1);
    idle();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_wbusy", {31'h0, wbusy}, 32'h0);
    check("arst_led", {24'h0, led}, 32'h0);
    sel = 2'b11; #1 check("arst_result", rdata, 32'h0);
    sel = 2'b00; #1 check("arst_a", rdata, 32'h0);
    sel = 2'b01; #1 check("arst_b", rdata, 32'h0);
    sel = 2'b10; #1 check("arst_status", rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("arst_stays_idle", {31'h0, wbusy}, 32'h0);

    check("queue_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
